// File: rtl/memristor_pkg.sv
// Shared types and constants for the memristor programming front-end.
// Holds the driver state encoding, direction codes and default widths.
// No logic lives here; every consumer imports it.
package memristor_pkg;

   localparam int CNT_W_DEF = 8;
   localparam int LEN_W_DEF = 8;

   localparam logic DIR_INC = 1'b1;
   localparam logic DIR_DEC = 1'b0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/memristor_pulse_timer.sv
// Loadable down-counter timing one pulse or one gap phase.
// expire is high during the final cycle of a loaded interval (count == 1).
// load has priority over run; a loaded value of 0 never expires, so callers clamp to >= 1.
module memristor_pulse_timer #(
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [LEN_W-1:0] load_val,
   input  logic             run,
   output logic             expire
);

   logic [LEN_W-1:0] cnt_q;
   logic [LEN_W-1:0] cnt_d;

   // Next count: reload, count down while running, otherwise hold.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (run && (cnt_q != '0)) begin
         cnt_d = cnt_q - LEN_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/memristor_pulse_driver.sv
// Turns a write request into a registered train of rInc or rDec pulses.
// First pulse high one cycle after accept; busy lasts count*plen + (count-1)*glen + 1 cycles.
// req_ready only in IDLE; abort in PULSE/GAP retires the train on the next cycle.
module memristor_pulse_driver
   import memristor_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_dir,
   input  logic [CNT_W-1:0] req_count,
   input  logic [LEN_W-1:0] pulse_len,
   input  logic [LEN_W-1:0] gap_len,
   input  logic             abort,
   output logic             rInc,
   output logic             rDec,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [CNT_W-1:0] pulses_sent
);

   state_t           state_q, state_d;
   logic             rinc_q, rinc_d;
   logic             rdec_q, rdec_d;
   logic             done_q, done_d;
   logic             aborted_q, aborted_d;
   logic [CNT_W-1:0] sent_q, sent_d;
   logic             dir_q, dir_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [LEN_W-1:0] plen_q, plen_d;
   logic [LEN_W-1:0] glen_q, glen_d;

   logic             tmr_load;
   logic [LEN_W-1:0] tmr_val;
   logic             tmr_run;
   logic             tmr_expire;

   logic [LEN_W-1:0] plen_clamp;
   logic [LEN_W-1:0] glen_clamp;
   logic             accept;
   // One extra bit so count = all-ones retires without wrapping.
   logic [CNT_W:0]   sent_inc;
   logic             last_pulse;

   assign plen_clamp = (pulse_len == '0) ? LEN_W'(1) : pulse_len;
   assign glen_clamp = (gap_len == '0) ? LEN_W'(1) : gap_len;
   assign accept     = req_valid && (state_q == IDLE);
   assign sent_inc   = {1'b0, sent_q} + (CNT_W+1)'(1);
   assign last_pulse = (sent_inc == {1'b0, count_q});

   memristor_pulse_timer #(.LEN_W(LEN_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .run      (tmr_run),
      .expire   (tmr_expire)
   );

   // Next-state and next-output logic; drive outputs are computed one cycle ahead so they come from flops.
   always_comb begin
      state_d   = state_q;
      rinc_d    = 1'b0;
      rdec_d    = 1'b0;
      done_d    = 1'b0;
      aborted_d = aborted_q;
      sent_d    = sent_q;
      dir_d     = dir_q;
      count_d   = count_q;
      plen_d    = plen_q;
      glen_d    = glen_q;
      tmr_load  = 1'b0;
      tmr_val   = plen_q;
      tmr_run   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               dir_d     = req_dir;
               count_d   = req_count;
               plen_d    = plen_clamp;
               glen_d    = glen_clamp;
               sent_d    = '0;
               aborted_d = 1'b0;
               if (req_count != '0) begin
                  state_d  = PULSE;
                  tmr_load = 1'b1;
                  tmr_val  = plen_clamp;
                  rinc_d   = (req_dir == DIR_INC);
                  rdec_d   = (req_dir == DIR_DEC);
               end else begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end
         end
         PULSE: begin
            tmr_run = 1'b1;
            if (abort) begin
               // Partial pulse is dropped and never counted.
               state_d   = DONE;
               done_d    = 1'b1;
               aborted_d = 1'b1;
            end else if (tmr_expire) begin
               sent_d = sent_inc[CNT_W-1:0];
               if (last_pulse) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d  = GAP;
                  tmr_load = 1'b1;
                  tmr_val  = glen_q;
               end
            end else begin
               rinc_d = (dir_q == DIR_INC);
               rdec_d = (dir_q == DIR_DEC);
            end
         end
         GAP: begin
            tmr_run = 1'b1;
            if (abort) begin
               state_d   = DONE;
               done_d    = 1'b1;
               aborted_d = 1'b1;
            end else if (tmr_expire) begin
               state_d  = PULSE;
               tmr_load = 1'b1;
               tmr_val  = plen_q;
               rinc_d   = (dir_q == DIR_INC);
               rdec_d   = (dir_q == DIR_DEC);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, latched request and registered outputs; reset forces both drives low immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rinc_q    <= 1'b0;
         rdec_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         sent_q    <= '0;
         dir_q     <= DIR_DEC;
         count_q   <= '0;
         plen_q    <= LEN_W'(1);
         glen_q    <= LEN_W'(1);
      end else begin
         state_q   <= state_d;
         rinc_q    <= rinc_d;
         rdec_q    <= rdec_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
         sent_q    <= sent_d;
         dir_q     <= dir_d;
         count_q   <= count_d;
         plen_q    <= plen_d;
         glen_q    <= glen_d;
      end
   end

   assign rInc        = rinc_q;
   assign rDec        = rdec_q;
   assign done        = done_q;
   assign aborted     = aborted_q;
   assign pulses_sent = sent_q;
   assign busy        = (state_q != IDLE);
   assign req_ready   = (state_q == IDLE);

endmodule

// File: tb/tb_memristor_pulse_driver.sv
// Directed bench for memristor_pulse_driver with a per-cycle expected-output scoreboard.
// Expected vectors are built from the request parameters when a request is issued.
// Each cycle is sampled on the falling edge and compared against the queue head.
module tb_memristor_pulse_driver;

   localparam int CNT_W = 8;
   localparam int LEN_W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req_valid;
   logic             req_ready;
   logic             req_dir;
   logic [CNT_W-1:0] req_count;
   logic [LEN_W-1:0] pulse_len;
   logic [LEN_W-1:0] gap_len;
   logic             abort;
   logic             rInc;
   logic             rDec;
   logic             busy;
   logic             done;
   logic             aborted;
   logic [CNT_W-1:0] pulses_sent;

   typedef struct packed {
      logic             rinc;
      logic             rdec;
      logic             done;
      logic             aborted;
      logic             busy;
      logic             ready;
      logic [CNT_W-1:0] sent;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   memristor_pulse_driver #(.CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_dir     (req_dir),
      .req_count   (req_count),
      .pulse_len   (pulse_len),
      .gap_len     (gap_len),
      .abort       (abort),
      .rInc        (rInc),
      .rDec        (rDec),
      .busy        (busy),
      .done        (done),
      .aborted     (aborted),
      .pulses_sent (pulses_sent)
   );

   function automatic obs_t mk(logic ri, logic rd, logic dn, logic ab, logic bz, logic rdy, int snt);
      obs_t o;
      o.rinc    = ri;
      o.rdec    = rd;
      o.done    = dn;
      o.aborted = ab;
      o.busy    = bz;
      o.ready   = rdy;
      o.sent    = CNT_W'(snt);
      return o;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.rinc    = rInc;
      o.rdec    = rDec;
      o.done    = done;
      o.aborted = aborted;
      o.busy    = busy;
      o.ready   = req_ready;
      o.sent    = pulses_sent;
      return o;
   endfunction

   // Expected cycles 1.. after accept for an uninterrupted train, plus the following idle cycle.
   task automatic push_train(logic dir, int cnt, int pl, int gl);
      int p;
      int g;
      p = (pl == 0) ? 1 : pl;
      g = (gl == 0) ? 1 : gl;
      for (int k = 0; k < cnt; k++) begin
         for (int i = 0; i < p; i++) exp_q.push_back(mk(dir, !dir, 1'b0, 1'b0, 1'b1, 1'b0, k));
         if (k != cnt - 1)
            for (int i = 0; i < g; i++) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, k + 1));
      end
      exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, cnt));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cnt));
   endtask

   task automatic check_one(string tag);
      obs_t o;
      obs_t e;
      @(negedge clk);
      o = sample();
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL %s: observed %h with empty scoreboard", tag, o);
      end else begin
         e = exp_q.pop_front();
         assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
         end
      end
   endtask

   task automatic drain(string tag);
      while (exp_q.size() > 0) check_one(tag);
   endtask

   // Accept happens on the rising edge after this call's falling edge (cycle 0); inputs are scrambled afterwards.
   task automatic issue(logic dir, int cnt, int pl, int gl, string tag);
      @(negedge clk);
      req_dir   = dir;
      req_count = CNT_W'(cnt);
      pulse_len = LEN_W'(pl);
      gap_len   = LEN_W'(gl);
      req_valid = 1'b1;
      checks++;
      assert (req_ready === 1'b1) else begin
         errors++;
         $error("FAIL %s_ready: observed %b expected 1", tag, req_ready);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_dir   = ~dir;
      req_count = CNT_W'($urandom);
      pulse_len = LEN_W'($urandom);
      gap_len   = LEN_W'($urandom);
   endtask

   initial begin
      obs_t idle0;
      idle0     = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_dir   = 1'b0;
      req_count = '0;
      pulse_len = '0;
      gap_len   = '0;
      abort     = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset state.
      exp_q.push_back(idle0);
      check_one("reset");

      // Increment train, count=3 plen=2 glen=1.
      issue(1'b1, 3, 2, 1, "inc3");
      push_train(1'b1, 3, 2, 1);
      drain("inc3");

      // Decrement train with both lengths clamped from 0 to 1.
      issue(1'b0, 2, 0, 0, "dec2");
      push_train(1'b0, 2, 0, 0);
      drain("dec2");

      // Zero-count request retires immediately with no pulse.
      issue(1'b1, 0, 5, 5, "cnt0");
      push_train(1'b1, 0, 5, 5);
      drain("cnt0");

      // Abort during the first pulse (asserted in cycle 3).
      issue(1'b1, 5, 4, 2, "abort");
      for (int i = 0; i < 3; i++) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0));
      check_one("abort");
      check_one("abort");
      check_one("abort");
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      drain("abort");

      // Abort in IDLE is ignored; aborted flag holds.
      abort = 1'b1;
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0));
      drain("abort_idle");
      abort = 1'b0;

      // Full-range count completes without wrap; next accept clears aborted.
      issue(1'b0, 255, 0, 0, "cnt255");
      push_train(1'b0, 255, 0, 0);
      drain("cnt255");

      // Reset in cycle 5 of a running train.
      issue(1'b1, 4, 3, 1, "rst");
      push_train(1'b1, 4, 3, 1);
      for (int i = 0; i < 4; i++) check_one("rst_pre");
      exp_q.delete();
      @(posedge clk);
      #1;
      checks++;
      assert (rInc === 1'b1) else begin
         errors++;
         $error("FAIL rst_c5_rinc: observed %b expected 1", rInc);
      end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      assert (sample() === idle0) else begin
         errors++;
         $error("FAIL rst_async: observed %h expected %h", sample(), idle0);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         assert (sample() === idle0) else begin
            errors++;
            $error("FAIL rst_hold: observed %h expected %h", sample(), idle0);
         end
      end
      rst_n = 1'b1;
      exp_q.push_back(idle0);
      check_one("rst_post");

      // Fresh request after reset.
      issue(1'b0, 1, 2, 3, "post_rst");
      push_train(1'b0, 1, 2, 3);
      drain("post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
